// File: rtl/ff_pause_if.sv
// Signal bundle for the pausable load register: functional load/pause controls,
// registered outputs, and the word-serial scan path.
interface ff_pause_if #(
    parameter int WIDTH      = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int SCAN_WIDTH = 64
);
    logic                  pause;
    logic                  en;
    logic [WIDTH-1:0]      d;
    logic [WIDTH-1:0]      q;
    logic [CNT_WIDTH-1:0]  count;
    logic                  scan_en;
    logic [SCAN_WIDTH-1:0] scan_di;
    logic [SCAN_WIDTH-1:0] scan_do;

    modport master (
        output pause, en, d, scan_en, scan_di,
        input  q, count, scan_do
    );

    modport slave (
        input  pause, en, d, scan_en, scan_di,
        output q, count, scan_do
    );
endinterface

// File: rtl/ff_pause.sv
// Pausable load-enable register with a shadow load counter; the whole state
// {count, q} is exposed as a word-serial scan chain for checkpoint save/restore.
module ff_pause #(
    parameter int WIDTH      = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int SCAN_WIDTH = 64
) (
    input  logic clock,
    input  logic reset,
    ff_pause_if.slave bus
);
    localparam int STATE_BITS = WIDTH + CNT_WIDTH;
    localparam int N_WORDS    = (STATE_BITS + SCAN_WIDTH - 1) / SCAN_WIDTH;
    localparam int TOTAL_BITS = N_WORDS * SCAN_WIDTH;

    logic [WIDTH-1:0]      q_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic [TOTAL_BITS-1:0] state_vec;
    logic [TOTAL_BITS-1:0] shift_vec;

    // Zero-extension keeps the padding bits of the chain reading as 0.
    assign state_vec = TOTAL_BITS'({count_reg, q_reg});

    // One scan step moves every word toward the head and loads scan_di at the tail.
    genvar gi;
    generate
        for (gi = 0; gi < N_WORDS - 1; gi++) begin : g_shift
            assign shift_vec[gi*SCAN_WIDTH +: SCAN_WIDTH] =
                state_vec[(gi+1)*SCAN_WIDTH +: SCAN_WIDTH];
        end
    endgenerate
    assign shift_vec[(N_WORDS-1)*SCAN_WIDTH +: SCAN_WIDTH] = bus.scan_di;

    // Scan wins over pause, pause wins over a functional load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_reg     <= '0;
            count_reg <= '0;
        end else if (bus.scan_en) begin
            {count_reg, q_reg} <= shift_vec[STATE_BITS-1:0];
        end else if (!bus.pause && bus.en) begin
            q_reg     <= bus.d;
            count_reg <= count_reg + 1'b1;
        end
    end

    assign bus.q       = q_reg;
    assign bus.count   = count_reg;
    assign bus.scan_do = state_vec[SCAN_WIDTH-1:0];
endmodule

// File: tb/tb_ff_pause.sv
// Scoreboard bench for ff_pause: a reference model pushes expected state per
// transaction, and the observed q/count/scan_do are popped and compared.
module tb_ff_pause;
    logic clock;
    logic reset;

    ff_pause_if #(.WIDTH(32), .CNT_WIDTH(32), .SCAN_WIDTH(64)) bus ();

    ff_pause #(.WIDTH(32), .CNT_WIDTH(32), .SCAN_WIDTH(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] q;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_q      = '0;
    logic [31:0] m_cnt    = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.q   = m_q;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_q"},       {32'd0, bus.q},     {32'd0, e.q});
        check({tag, "_count"},   {32'd0, bus.count}, {32'd0, e.cnt});
        check({tag, "_scan_do"}, bus.scan_do,        {e.cnt, e.q});
        $display("%s: q=%h count=%h scan_do=%h", tag, bus.q, bus.count, bus.scan_do);
    endtask

    // One clocked transaction; loop=1 feeds scan_do back into scan_di.
    task automatic cycle(input string tag, input logic rstn, input logic p, input logic e,
                         input logic [31:0] dv, input logic se, input logic loop,
                         input logic [63:0] sdi);
        @(negedge clock);
        reset       = rstn;
        bus.pause   = p;
        bus.en      = e;
        bus.d       = dv;
        bus.scan_en = se;
        bus.scan_di = loop ? bus.scan_do : sdi;
        if (!rstn) begin
            m_q   = '0;
            m_cnt = '0;
        end else if (se) begin
            if (!loop) {m_cnt, m_q} = sdi;
        end else if (!p && e) begin
            m_q   = dv;
            m_cnt = m_cnt + 1;
        end
        push_model();
        @(posedge clock);
        #1;
        pop_compare(tag);
    endtask

    initial begin
        reset       = 1'b1;
        bus.pause   = 1'b0;
        bus.en      = 1'b0;
        bus.d       = '0;
        bus.scan_en = 1'b0;
        bus.scan_di = '0;

        // Async reset must clear state before any clock edge.
        #1 reset = 1'b0;
        #1;
        push_model();
        pop_compare("reset_async");

        cycle("load",  1, 0, 1, 32'hDEADBEEF, 0, 0, 64'd0);
        for (int i = 0; i < 3; i++)
            cycle("hold", 1, 0, 0, 32'd0, 0, 0, 64'd0);

        for (int i = 0; i < 5; i++)
            cycle("paused", 1, 1, 1, 32'h12345678, 0, 0, 64'd0);
        cycle("unpause", 1, 0, 1, 32'h12345678, 0, 0, 64'd0);

        cycle("scan_load", 1, 1, 1, 32'h11111111, 1, 0, 64'h0000_0007_CAFEF00D);
        cycle("scan_loop", 1, 0, 1, 32'h22222222, 1, 1, 64'd0);
        cycle("resume",    1, 0, 1, 32'h33333333, 0, 0, 64'd0);

        cycle("set_max", 1, 0, 0, 32'd0, 1, 0, 64'hFFFF_FFFF_0BAD_F00D);
        cycle("wrap",    1, 0, 1, 32'hA5A5A5A5, 0, 0, 64'd0);

        // Reset asserted between edges while scanning.
        cycle("pre_scan", 1, 0, 0, 32'd0, 1, 0, 64'h1234_5678_9ABC_DEF0);
        @(negedge clock);
        bus.scan_en = 1'b1;
        bus.scan_di = 64'hFFFF_FFFF_FFFF_FFFF;
        #2 reset = 1'b0;
        #1;
        m_q   = '0;
        m_cnt = '0;
        push_model();
        pop_compare("reset_mid_scan");
        cycle("reset_held", 0, 0, 1, 32'h55555555, 1, 0, 64'h1);
        cycle("post_reset", 1, 0, 1, 32'h66666666, 0, 0, 64'd0);

        for (int i = 0; i < 300; i++) begin
            logic        rstn;
            logic        se;
            rstn = ($urandom_range(0, 39) != 0);
            se   = ($urandom_range(0, 7) == 0);
            cycle("rand", rstn, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                  $urandom, se, 1'b0, {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
